// File: rtl/rv32i_types.sv
// Shared RV32I types for the MEM stage: data word, load/store funct3 encodings, MEM FSM states.
// Latency: n/a (types and pure helper function only).
// Backpressure: n/a.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // funct3[1:0] selects width identically for loads and stores:
    // 01 = halfword, 10 = word, anything else is byte-sized and never misaligned.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] bs);
        case (f3[1:0])
            2'b01:   return bs[0];
            2'b10:   return (bs != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Formats a raw memory word into the load result: lane select by bit_shift, then sign/zero extend.
// Latency: purely combinational.
// Backpressure: none.
// Ports: funct3/bit_shift select the format, rdata is the raw word, load_data the formatted result.
module mem_load_align
    import rv32i_types::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] bit_shift,
    input  rv32i_word  rdata,
    output rv32i_word  load_data
);

    rv32i_word shifted;
    assign shifted = rdata >> {bit_shift, 3'b000};

    always_comb begin
        load_data = rdata;
        case (load_funct3_t'(funct3))
            lb:      load_data = {{24{shifted[7]}}, shifted[7:0]};
            lh:      load_data = {{16{shifted[15]}}, shifted[15:0]};
            lbu:     load_data = {24'h000000, shifted[7:0]};
            lhu:     load_data = {16'h0000, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: latches one load/store from EX/MEM, runs a data-memory handshake, returns formatted load data.
// Latency: stall held k+1 cycles for a response after k ACCESS cycles (min 2); result strobed in DONE.
// Backpressure: mem_stall freezes the pipeline until dmem_resp; request outputs held stable meanwhile.
// Ports: EX/MEM ctrl (mem_read/mem_write/funct3/addr/bit_shift/write_data/mem_byte_en), dmem_* request/response,
//        mem_stall, load_data/load_valid, access_cycles (saturating CNT_W count), misalign_fault.
// Option: define MEM_MISALIGN_CHK_EN to reject misaligned lh/lhu/sh/lw/sw without touching memory.
module mem_access_unit
    import rv32i_types::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [1:0]       bit_shift,
    input  logic [31:0]      write_data,
    input  logic [3:0]       mem_byte_en,
    input  logic             dmem_resp,
    input  logic [31:0]      dmem_rdata,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [31:0]      dmem_address,
    output logic [31:0]      dmem_wdata,
    output logic [3:0]       dmem_wmask,
    output logic             mem_stall,
    output logic [31:0]      load_data,
    output logic             load_valid,
    output logic [CNT_W-1:0] access_cycles,
    output logic             misalign_fault
);

    mem_state_t       state_q, state_d;
    rv32i_word        addr_q, addr_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       bshift_q, bshift_d;
    rv32i_word        wdata_q, wdata_d;
    logic [3:0]       wmask_q, wmask_d;
    logic             is_rd_q, is_rd_d;
    logic             is_wr_q, is_wr_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] acyc_q, acyc_d;
    rv32i_word        ldata_q, ldata_d;

    logic             req;
    logic             in_access;
    logic             misalign;
    logic [CNT_W-1:0] cnt_inc;
    rv32i_word        store_shifted;
    rv32i_word        aligned_rdata;

    assign req       = mem_read | mem_write;
    assign in_access = (state_q == ACCESS);
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef MEM_MISALIGN_CHK_EN
    assign misalign       = is_misaligned(funct3, bit_shift);
    assign misalign_fault = (state_q == DONE) & fault_q;
`else
    assign misalign       = 1'b0;
    assign misalign_fault = 1'b0;
`endif

    always_comb begin
        store_shifted = write_data;
        case (store_funct3_t'(funct3))
            sh:      store_shifted = {16'h0000, write_data[15:0]} << {bit_shift, 3'b000};
            sb:      store_shifted = {24'h000000, write_data[7:0]} << {bit_shift, 3'b000};
            default: store_shifted = write_data;
        endcase
    end

    // Formatting uses the latched op so the raw word is only sampled with dmem_resp.
    mem_load_align u_load_align (
        .funct3    (funct3_q),
        .bit_shift (bshift_q),
        .rdata     (dmem_rdata),
        .load_data (aligned_rdata)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        bshift_d = bshift_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        is_rd_d  = is_rd_q;
        is_wr_d  = is_wr_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        acyc_d   = acyc_q;
        ldata_d  = ldata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d   = addr;
                    funct3_d = funct3;
                    bshift_d = bit_shift;
                    wdata_d  = store_shifted;
                    // A store overrides a simultaneous load; the mask is meaningless for loads.
                    is_wr_d  = mem_write;
                    is_rd_d  = mem_read & ~mem_write;
                    wmask_d  = mem_write ? mem_byte_en : 4'b0000;
                    cnt_d    = '0;
                    fault_d  = misalign;
                    if (misalign) begin
                        acyc_d  = '0;
                        state_d = DONE;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_inc;
                if (dmem_resp) begin
                    acyc_d  = cnt_inc;
                    state_d = DONE;
                    if (is_rd_q) begin
                        ldata_d = aligned_rdata;
                    end
                end
            end
            DONE: begin
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            bshift_q <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            is_rd_q  <= 1'b0;
            is_wr_q  <= 1'b0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
            acyc_q   <= '0;
            ldata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            bshift_q <= bshift_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            is_rd_q  <= is_rd_d;
            is_wr_q  <= is_wr_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
            acyc_q   <= acyc_d;
            ldata_q  <= ldata_d;
        end
    end

    // Requests derive from state_q, so an asynchronous reset drops them immediately.
    assign dmem_read     = in_access & is_rd_q;
    assign dmem_write    = in_access & is_wr_q;
    assign dmem_address  = in_access ? addr_q  : 32'h0;
    assign dmem_wdata    = in_access ? wdata_q : 32'h0;
    assign dmem_wmask    = in_access ? wmask_q : 4'b0000;
    assign mem_stall     = ((state_q == IDLE) & req) | in_access;
    assign load_data     = ldata_q;
    assign load_valid    = (state_q == DONE) & is_rd_q & ~fault_q;
    assign access_cycles = acyc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops push expectations, a monitor checks each completion.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [1:0]  bit_shift;
    logic [31:0] write_data;
    logic [3:0]  mem_byte_en;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic [7:0]  access_cycles;
    logic        misalign_fault;

    mem_access_unit #(.CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .addr           (addr),
        .bit_shift      (bit_shift),
        .write_data     (write_data),
        .mem_byte_en    (mem_byte_en),
        .dmem_resp      (dmem_resp),
        .dmem_rdata     (dmem_rdata),
        .dmem_read      (dmem_read),
        .dmem_write     (dmem_write),
        .dmem_address   (dmem_address),
        .dmem_wdata     (dmem_wdata),
        .dmem_wmask     (dmem_wmask),
        .mem_stall      (mem_stall),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .access_cycles  (access_cycles),
        .misalign_fault (misalign_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        lv;
        logic [31:0] ldata;
        logic [7:0]  cyc;
        int          stall;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    function automatic exp_t mk(input string nm, input logic rd, input logic wr,
                                input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                                input logic lv, input logic [31:0] ld, input logic [7:0] cyc,
                                input int stall, input logic fault);
        exp_t e;
        e.name = nm; e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd; e.wmask = wm;
        e.lv = lv; e.ldata = ld; e.cyc = cyc; e.stall = stall; e.fault = fault;
        return e;
    endfunction

    // ---------------- monitor ----------------
    int          stall_cnt  = 0;
    logic        prev_stall = 1'b0;
    logic        seen = 1'b0, unstable = 1'b0, lv_follow = 1'b0;
    logic        s_rd, s_wr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wmask;

    always @(negedge clk) begin
        if (!rst) begin
            stall_cnt = 0; prev_stall = 1'b0; seen = 1'b0; unstable = 1'b0; lv_follow = 1'b0;
        end else begin
            if (lv_follow) begin
                chk("load_valid_one_cycle", {31'b0, load_valid}, 32'h0);
                lv_follow = 1'b0;
            end
            if (dmem_read | dmem_write) begin
                if (!seen) begin
                    seen = 1'b1; s_rd = dmem_read; s_wr = dmem_write;
                    s_addr = dmem_address; s_wdata = dmem_wdata; s_wmask = dmem_wmask;
                end else if ({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_wmask} !==
                             {s_rd, s_wr, s_addr, s_wdata, s_wmask}) begin
                    unstable = 1'b1;
                end
            end
            if (mem_stall) begin
                stall_cnt++;
            end else if (prev_stall) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_completion: got a completion, expected none queued");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, ".dmem_read"},  {31'b0, seen & s_rd}, {31'b0, e.rd});
                    chk({e.name, ".dmem_write"}, {31'b0, seen & s_wr}, {31'b0, e.wr});
                    if (e.rd | e.wr) begin
                        chk({e.name, ".address"},  s_addr, e.addr);
                        chk({e.name, ".wmask"},    {28'b0, s_wmask}, {28'b0, e.wmask});
                        chk({e.name, ".stable"},   {31'b0, unstable}, 32'h0);
                    end
                    if (e.wr) chk({e.name, ".wdata"}, s_wdata, e.wdata);
                    chk({e.name, ".load_valid"}, {31'b0, load_valid}, {31'b0, e.lv});
                    if (e.lv) chk({e.name, ".load_data"}, load_data, e.ldata);
                    chk({e.name, ".access_cycles"}, {24'b0, access_cycles}, {24'b0, e.cyc});
                    chk({e.name, ".stall_cycles"}, stall_cnt, e.stall);
                    chk({e.name, ".misalign_fault"}, {31'b0, misalign_fault}, {31'b0, e.fault});
                    lv_follow = e.lv;
                end
                stall_cnt = 0; seen = 1'b0; unstable = 1'b0;
            end
            prev_stall = mem_stall;
        end
    end

    // ---------------- stimulus ----------------
    // k = number of ACCESS cycles before dmem_resp (response in the k-th); k = 0 means no memory access.
    task automatic run_op(input exp_t e, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [1:0] bs, input logic [31:0] wd,
                          input logic [3:0] be, input int k, input logic [31:0] rdata);
        exp_q.push_back(e);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; bit_shift = bs;
        write_data = wd; mem_byte_en = be;
        @(posedge clk); #1;
        if (k > 0) begin
            for (int i = 1; i < k; i++) begin
                @(posedge clk); #1;
            end
            dmem_resp = 1'b1; dmem_rdata = rdata;
            @(posedge clk); #1;
            dmem_resp = 1'b0; dmem_rdata = 32'h0;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = 32'h0;
        bit_shift = 2'b00; write_data = 32'h0; mem_byte_en = 4'h0; dmem_resp = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk); @(negedge clk);
        chk("reset.dmem_read",      {31'b0, dmem_read}, 32'h0);
        chk("reset.dmem_write",     {31'b0, dmem_write}, 32'h0);
        chk("reset.mem_stall",      {31'b0, mem_stall}, 32'h0);
        chk("reset.load_valid",     {31'b0, load_valid}, 32'h0);
        chk("reset.load_data",      load_data, 32'h0);
        chk("reset.access_cycles",  {24'b0, access_cycles}, 32'h0);
        chk("reset.misalign_fault", {31'b0, misalign_fault}, 32'h0);
        chk("reset.dmem_address",   dmem_address, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        //            name       rd    wr    addr          wdata         wm     lv    ldata         cyc  stall fault
        run_op(mk("lb_b3",    1'b1, 1'b0, 32'h0000_1000, 32'h0,        4'h0,  1'b1, 32'hFFFF_FF80, 8'd1, 2, 1'b0),
               1'b1, 1'b0, 3'b000, 32'h0000_1000, 2'd3, 32'h0, 4'h0, 1, 32'h80FF_FF00);
        run_op(mk("sh_b2",    1'b0, 1'b1, 32'h0000_1004, 32'h1234_0000, 4'hC, 1'b0, 32'h0,        8'd3, 4, 1'b0),
               1'b0, 1'b1, 3'b001, 32'h0000_1004, 2'd2, 32'h0000_1234, 4'hC, 3, 32'h0);
        run_op(mk("lhu_b2",   1'b1, 1'b0, 32'h0000_1008, 32'h0,        4'h0,  1'b1, 32'h0000_BEEF, 8'd5, 6, 1'b0),
               1'b1, 1'b0, 3'b101, 32'h0000_1008, 2'd2, 32'h0, 4'h0, 5, 32'hBEEF_0000);
        run_op(mk("lh_b0",    1'b1, 1'b0, 32'h0000_100C, 32'h0,        4'h0,  1'b1, 32'hFFFF_8001, 8'd2, 3, 1'b0),
               1'b1, 1'b0, 3'b001, 32'h0000_100C, 2'd0, 32'h0, 4'h0, 2, 32'h0000_8001);
        run_op(mk("lbu_b1",   1'b1, 1'b0, 32'h0000_1010, 32'h0,        4'h0,  1'b1, 32'h0000_00AB, 8'd1, 2, 1'b0),
               1'b1, 1'b0, 3'b100, 32'h0000_1010, 2'd1, 32'h0, 4'h0, 1, 32'h0000_AB00);
        run_op(mk("lw",       1'b1, 1'b0, 32'h0000_1014, 32'h0,        4'h0,  1'b1, 32'hDEAD_BEEF, 8'd1, 2, 1'b0),
               1'b1, 1'b0, 3'b010, 32'h0000_1014, 2'd0, 32'h0, 4'h0, 1, 32'hDEAD_BEEF);
        run_op(mk("sb_b1",    1'b0, 1'b1, 32'h0000_1018, 32'h0000_A500, 4'h2, 1'b0, 32'h0,        8'd1, 2, 1'b0),
               1'b0, 1'b1, 3'b000, 32'h0000_1018, 2'd1, 32'h0000_00A5, 4'h2, 1, 32'h0);
        run_op(mk("sw",       1'b0, 1'b1, 32'h0000_101C, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0,        8'd2, 3, 1'b0),
               1'b0, 1'b1, 3'b010, 32'h0000_101C, 2'd0, 32'hCAFE_F00D, 4'hF, 2, 32'h0);
        run_op(mk("rd_and_wr",1'b0, 1'b1, 32'h0000_2000, 32'h1122_3344, 4'hF, 1'b0, 32'h0,        8'd1, 2, 1'b0),
               1'b1, 1'b1, 3'b010, 32'h0000_2000, 2'd0, 32'h1122_3344, 4'hF, 1, 32'h0);
        run_op(mk("saturate", 1'b1, 1'b0, 32'h0000_2004, 32'h0,        4'h0,  1'b1, 32'h0000_0042, 8'd255, 261, 1'b0),
               1'b1, 1'b0, 3'b010, 32'h0000_2004, 2'd0, 32'h0, 4'h0, 260, 32'h0000_0042);

        // Reset in the middle of an ACCESS: request drops without waiting for a clock.
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_3000; bit_shift = 2'd0;
        @(posedge clk); #1;
        chk("rst_mid.read_before", {31'b0, dmem_read}, 32'h1);
        #2 rst = 1'b0; mem_read = 1'b0;
        #1;
        chk("rst_mid.read_dropped", {31'b0, dmem_read}, 32'h0);
        chk("rst_mid.stall_dropped", {31'b0, mem_stall}, 32'h0);
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_resp = 1'b0; dmem_rdata = 32'h0;
        chk("stray_resp.stall", {31'b0, mem_stall}, 32'h0);
        chk("stray_resp.load_valid", {31'b0, load_valid}, 32'h0);
        chk("stray_resp.dmem_read", {31'b0, dmem_read}, 32'h0);
        run_op(mk("after_rst", 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 1'b1, 32'h55AA_55AA, 8'd1, 2, 1'b0),
               1'b1, 1'b0, 3'b010, 32'h0000_3000, 2'd0, 32'h0, 4'h0, 1, 32'h55AA_55AA);

`ifdef MEM_MISALIGN_CHK_EN
        run_op(mk("lw_misalign", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 8'd0, 1, 1'b1),
               1'b1, 1'b0, 3'b010, 32'h0000_4000, 2'd1, 32'h0, 4'h0, 0, 32'h0);
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, expected completion earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
